// File: rtl/a_io_l3_in_serialize_a_m_axi_req_arbiter.sv
// Round-robin arbiter sharing one m_axi read burst converter between several word-granular
// requesters; a tag FIFO steers returned beats back to the port that issued each request.
module a_io_l3_in_serialize_a_m_axi_req_arbiter #(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 24,
   parameter int OST_DEPTH  = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] in_REQ_ADDR,
   input  logic [NUM_PORTS*LEN_WIDTH-1:0]  in_REQ_LEN,
   input  logic [NUM_PORTS-1:0]            in_REQ_VALID,
   output logic [NUM_PORTS-1:0]            out_REQ_READY,
   output logic [ADDR_WIDTH-1:0]           out_REQ_ADDR,
   output logic [31:0]                     out_REQ_LEN,
   output logic                            out_REQ_VALID,
   input  logic                            in_REQ_READY_C,
   input  logic [DATA_WIDTH-1:0]           in_RDATA,
   input  logic                            in_RDATA_VALID,
   output logic                            out_RDATA_READY,
   output logic [DATA_WIDTH-1:0]           out_RDATA,
   output logic                            out_RDATA_LAST,
   output logic [NUM_PORTS-1:0]            out_RDATA_VALID,
   input  logic [NUM_PORTS-1:0]            in_RDATA_READY
);

   localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int PTR_W      = $clog2(OST_DEPTH);
   localparam int CNT_W      = PTR_W + 1;
   localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

   logic                  req_valid_q;
   logic [ADDR_WIDTH-1:0] req_addr_q;
   logic [31:0]           req_len_q;
   logic [PORT_W-1:0]     rr_ptr;

   logic [PORT_W-1:0]     tag_port [OST_DEPTH];
   logic [LEN_WIDTH-1:0]  tag_len  [OST_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic [LEN_WIDTH-1:0]  beat_cnt;

   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  can_issue;
   logic                  grant_valid;
   logic [PORT_W-1:0]     grant_port;
   logic [PORT_W:0]       cand_sum;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [LEN_WIDTH-1:0]  sel_len;
   logic [31:0]           sel_byte_len;
   logic [PORT_W-1:0]     head_port;
   logic [LEN_WIDTH-1:0]  head_len;
   logic                  last_beat;
   logic                  ret_hs;
   logic                  push;
   logic                  pop;

   // Full is taken from the registered count, so a pop in the same cycle never frees a slot early.
   assign fifo_full  = (count == CNT_W'(OST_DEPTH));
   assign fifo_empty = (count == '0);
   assign can_issue  = (~req_valid_q | in_REQ_READY_C) & ~fifo_full & reset;

   always_comb begin
      grant_valid = 1'b0;
      grant_port  = '0;
      cand_sum    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand_sum = {1'b0, rr_ptr} + (PORT_W + 1)'(i);
         if (cand_sum >= (PORT_W + 1)'(NUM_PORTS)) begin
            cand_sum = cand_sum - (PORT_W + 1)'(NUM_PORTS);
         end
         if (!grant_valid && in_REQ_VALID[cand_sum[PORT_W-1:0]]) begin
            grant_valid = 1'b1;
            grant_port  = cand_sum[PORT_W-1:0];
         end
      end
      grant_valid = grant_valid & can_issue;
   end

   always_comb begin
      out_REQ_READY = '0;
      out_REQ_READY[grant_port] = grant_valid;
   end

   assign sel_addr     = in_REQ_ADDR[grant_port*ADDR_WIDTH +: ADDR_WIDTH];
   assign sel_len      = in_REQ_LEN[grant_port*LEN_WIDTH +: LEN_WIDTH];
   // Word count to byte count: (beats << log2(bytes per word)) - 1.
   assign sel_byte_len = ((32'(sel_len) + 32'd1) << BYTE_SHIFT) - 32'd1;

   assign head_port = tag_port[rd_ptr];
   assign head_len  = tag_len[rd_ptr];
   assign last_beat = (beat_cnt == head_len) & ~fifo_empty;

   assign out_RDATA_READY = ~fifo_empty & in_RDATA_READY[head_port] & reset;
   assign out_RDATA_LAST  = last_beat;
   assign out_RDATA       = in_RDATA;

   always_comb begin
      out_RDATA_VALID = '0;
      out_RDATA_VALID[head_port] = in_RDATA_VALID & ~fifo_empty & reset;
   end

   assign ret_hs = in_RDATA_VALID & out_RDATA_READY;
   assign push   = grant_valid;
   assign pop    = ret_hs & last_beat;

   assign out_REQ_ADDR  = req_addr_q;
   assign out_REQ_LEN   = req_len_q;
   assign out_REQ_VALID = req_valid_q & reset;

   always_ff @(posedge clk) begin
      if (!reset) begin
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         req_len_q   <= '0;
         rr_ptr      <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         beat_cnt    <= '0;
      end else begin
         if (push) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= sel_addr;
            req_len_q   <= sel_byte_len;
            wr_ptr      <= wr_ptr + 1'b1;
            if (grant_port == PORT_W'(NUM_PORTS - 1)) begin
               rr_ptr <= '0;
            end else begin
               rr_ptr <= grant_port + 1'b1;
            end
         end else if (in_REQ_READY_C) begin
            req_valid_q <= 1'b0;
         end

         if (ret_hs) begin
            if (last_beat) begin
               beat_cnt <= '0;
               rd_ptr   <= rd_ptr + 1'b1;
            end else begin
               beat_cnt <= beat_cnt + 1'b1;
            end
         end

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Tag storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         tag_port[wr_ptr] <= grant_port;
         tag_len[wr_ptr]  <= sel_len;
      end
   end

endmodule

// File: tb/tb_a_io_l3_in_serialize_a_m_axi_req_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a
// randomized run compared against a queue-based reference model.
module tb_a_io_l3_in_serialize_a_m_axi_req_arbiter;

   localparam int NP = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 24;
   localparam int OD = 16;

   logic             clk = 1'b0;
   logic             reset;
   logic [NP*AW-1:0] in_REQ_ADDR;
   logic [NP*LW-1:0] in_REQ_LEN;
   logic [NP-1:0]    in_REQ_VALID;
   logic [NP-1:0]    out_REQ_READY;
   logic [AW-1:0]    out_REQ_ADDR;
   logic [31:0]      out_REQ_LEN;
   logic             out_REQ_VALID;
   logic             in_REQ_READY_C;
   logic [DW-1:0]    in_RDATA;
   logic             in_RDATA_VALID;
   logic             out_RDATA_READY;
   logic [DW-1:0]    out_RDATA;
   logic             out_RDATA_LAST;
   logic [NP-1:0]    out_RDATA_VALID;
   logic [NP-1:0]    in_RDATA_READY;

   a_io_l3_in_serialize_a_m_axi_req_arbiter #(
      .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .OST_DEPTH(OD)
   ) dut (
      .clk(clk), .reset(reset),
      .in_REQ_ADDR(in_REQ_ADDR), .in_REQ_LEN(in_REQ_LEN), .in_REQ_VALID(in_REQ_VALID),
      .out_REQ_READY(out_REQ_READY), .out_REQ_ADDR(out_REQ_ADDR), .out_REQ_LEN(out_REQ_LEN),
      .out_REQ_VALID(out_REQ_VALID), .in_REQ_READY_C(in_REQ_READY_C),
      .in_RDATA(in_RDATA), .in_RDATA_VALID(in_RDATA_VALID), .out_RDATA_READY(out_RDATA_READY),
      .out_RDATA(out_RDATA), .out_RDATA_LAST(out_RDATA_LAST), .out_RDATA_VALID(out_RDATA_VALID),
      .in_RDATA_READY(in_RDATA_READY)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int port;
      int len;
   } tag_t;

   tag_t        m_q[$];
   bit          m_valid;
   logic [31:0] m_addr;
   logic [31:0] m_len;
   int          m_beat;
   int          m_rr;
   int          m_grant;
   bit          m_hs;

   logic [NP-1:0] seen_req_ready;
   logic [NP-1:0] seen_rdv;
   logic          seen_rrdy;
   logic          seen_last;

   typedef struct {
      bit          rst;
      logic [1:0]  vld;
      logic [31:0] addr0;
      logic [23:0] len0;
      bit          rdy_c;
      bit          rv;
      logic [1:0]  rrdy;
      logic [1:0]  e_req_ready;
      bit          e_valid;
      logic [31:0] e_addr;
      logic [31:0] e_len;
      logic [1:0]  e_rdv;
      bit          e_rrdy;
      bit          e_last;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input bit rst, input logic [1:0] vld,
                                 input logic [31:0] a0, input int l0,
                                 input logic [31:0] a1, input int l1,
                                 input bit rdy_c, input bit rv, input logic [1:0] rrdy);
      reset          = rst;
      in_REQ_VALID   = vld;
      in_REQ_ADDR    = {a1, a0};
      in_REQ_LEN     = {LW'(l1), LW'(l0)};
      in_REQ_READY_C = rdy_c;
      in_RDATA_VALID = rv;
      in_RDATA_READY = rrdy;
      in_RDATA       = $urandom;
   endtask

   function automatic void model_clear();
      m_q.delete();
      m_valid = 0;
      m_addr  = '0;
      m_len   = '0;
      m_beat  = 0;
      m_rr    = 0;
   endfunction

   // Expected behaviour derived from the queue of outstanding requests.
   task automatic check_output();
      bit          can;
      bit          empty;
      int          h;
      int          hl;
      logic [1:0]  e_rr;
      logic [1:0]  e_rdv;
      bit          e_rrdy;
      bit          e_last;
      empty = (m_q.size() == 0);
      h  = empty ? 0 : m_q[0].port;
      hl = empty ? 0 : m_q[0].len;
      can = reset && (!m_valid || in_REQ_READY_C) && (m_q.size() < OD);
      m_grant = -1;
      if (can) begin
         for (int i = 0; i < NP; i++) begin
            int p;
            p = (m_rr + i) % NP;
            if (m_grant < 0 && in_REQ_VALID[p]) m_grant = p;
         end
      end
      e_rr   = (m_grant >= 0) ? 2'(1 << m_grant) : 2'b00;
      e_rdv  = (reset && in_RDATA_VALID && !empty) ? 2'(1 << h) : 2'b00;
      e_rrdy = reset && !empty && in_RDATA_READY[h];
      e_last = !empty && (m_beat == hl);
      m_hs   = in_RDATA_VALID && e_rrdy;
      check("req_ready", 64'(out_REQ_READY), 64'(e_rr));
      check("req_valid", 64'(out_REQ_VALID), 64'(reset && m_valid));
      check("req_addr", 64'(out_REQ_ADDR), 64'(m_addr));
      check("req_len", 64'(out_REQ_LEN), 64'(m_len));
      check("rdata_valid", 64'(out_RDATA_VALID), 64'(e_rdv));
      check("rdata_ready", 64'(out_RDATA_READY), 64'(e_rrdy));
      check("rdata_last", 64'(out_RDATA_LAST), 64'(e_last));
      check("rdata", 64'(out_RDATA), 64'(in_RDATA));
   endtask

   function automatic void model_update();
      if (!reset) begin
         model_clear();
         return;
      end
      if (m_hs) begin
         if (m_beat == m_q[0].len) begin
            void'(m_q.pop_front());
            m_beat = 0;
         end else begin
            m_beat++;
         end
      end
      if (m_grant >= 0) begin
         tag_t t;
         t.port = m_grant;
         t.len  = int'(in_REQ_LEN[m_grant*LW +: LW]);
         m_q.push_back(t);
         m_valid = 1;
         m_addr  = in_REQ_ADDR[m_grant*AW +: AW];
         m_len   = 32'((t.len + 1) * (DW / 8) - 1);
         m_rr    = (m_grant + 1) % NP;
      end else if (in_REQ_READY_C) begin
         m_valid = 0;
      end
   endfunction

   task automatic cycle_model();
      @(negedge clk);
      check_output();
      seen_req_ready = out_REQ_READY;
      seen_rdv       = out_RDATA_VALID;
      seen_rrdy      = out_RDATA_READY;
      seen_last      = out_RDATA_LAST;
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      apply_stimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
      @(posedge clk);
      @(posedge clk);
      #1;
      model_clear();
      cycle_model();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int grants;
      int p0_beats;
      int p1_beats;
      int lasts;

      vecs[0] = '{0, 2'b11, 32'h1000, 24'd3, 1, 1, 2'b11, 2'b00, 0, 32'h0,    32'd0,  2'b00, 0, 0};
      vecs[1] = '{1, 2'b01, 32'h1000, 24'd3, 1, 1, 2'b11, 2'b01, 0, 32'h0,    32'd0,  2'b00, 0, 0};
      vecs[2] = '{1, 2'b00, 32'h1000, 24'd3, 1, 0, 2'b11, 2'b00, 1, 32'h1000, 32'd15, 2'b00, 1, 0};
      vecs[3] = '{1, 2'b00, 32'h1000, 24'd3, 1, 1, 2'b11, 2'b00, 0, 32'h1000, 32'd15, 2'b01, 1, 0};
      vecs[4] = '{1, 2'b00, 32'h1000, 24'd3, 1, 1, 2'b11, 2'b00, 0, 32'h1000, 32'd15, 2'b01, 1, 0};
      vecs[5] = '{1, 2'b00, 32'h1000, 24'd3, 1, 1, 2'b11, 2'b00, 0, 32'h1000, 32'd15, 2'b01, 1, 0};
      vecs[6] = '{1, 2'b00, 32'h1000, 24'd3, 1, 1, 2'b11, 2'b00, 0, 32'h1000, 32'd15, 2'b01, 1, 1};
      vecs[7] = '{1, 2'b00, 32'h1000, 24'd3, 1, 1, 2'b11, 2'b00, 0, 32'h1000, 32'd15, 2'b00, 0, 0};

      apply_stimulus(0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
      @(posedge clk);
      @(posedge clk);
      #1;

      // Single port-0 burst of four words, then a beat arriving with nothing outstanding.
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(vecs[i].rst, vecs[i].vld, vecs[i].addr0, int'(vecs[i].len0), 0, 0,
                        vecs[i].rdy_c, vecs[i].rv, vecs[i].rrdy);
         @(negedge clk);
         check($sformatf("vec%0d_req_ready", i), 64'(out_REQ_READY), 64'(vecs[i].e_req_ready));
         check($sformatf("vec%0d_req_valid", i), 64'(out_REQ_VALID), 64'(vecs[i].e_valid));
         check($sformatf("vec%0d_req_addr", i), 64'(out_REQ_ADDR), 64'(vecs[i].e_addr));
         check($sformatf("vec%0d_req_len", i), 64'(out_REQ_LEN), 64'(vecs[i].e_len));
         check($sformatf("vec%0d_rdata_valid", i), 64'(out_RDATA_VALID), 64'(vecs[i].e_rdv));
         check($sformatf("vec%0d_rdata_ready", i), 64'(out_RDATA_READY), 64'(vecs[i].e_rrdy));
         check($sformatf("vec%0d_rdata_last", i), 64'(out_RDATA_LAST), 64'(vecs[i].e_last));
         @(posedge clk);
         #1;
      end

      // Two ports contending with single-word requests alternate, and beats return in order.
      do_reset();
      apply_stimulus(1, 2'b11, 32'h100, 0, 32'h200, 0, 1, 0, 2'b11);
      for (int i = 0; i < 6; i++) begin
         cycle_model();
         check("rr_grant", 64'(seen_req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      end
      apply_stimulus(1, 2'b00, 0, 0, 0, 0, 1, 0, 2'b11);
      cycle_model();
      apply_stimulus(1, 2'b00, 0, 0, 0, 0, 1, 1, 2'b11);
      for (int i = 0; i < 6; i++) begin
         cycle_model();
         check("rr_route", 64'(seen_rdv), (i % 2 == 0) ? 64'd1 : 64'd2);
         check("rr_last", 64'(seen_last), 64'd1);
      end

      // Stalled converter holds one request; once released the tag FIFO fills to its depth.
      do_reset();
      grants = 0;
      apply_stimulus(1, 2'b01, 32'h4000, 0, 0, 0, 0, 0, 2'b11);
      for (int i = 0; i < 5; i++) begin
         cycle_model();
         if (seen_req_ready != 0) grants++;
      end
      check("stall_grants", 64'(grants), 64'd1);
      in_REQ_READY_C = 1'b1;
      for (int i = 0; i < 25; i++) begin
         cycle_model();
         if (seen_req_ready != 0) grants++;
      end
      check("full_grants", 64'(grants), 64'(OD));
      check("full_ready", 64'(seen_req_ready), 64'd0);
      in_RDATA_VALID = 1'b1;
      cycle_model();
      check("full_pop_last", 64'(seen_last), 64'd1);
      check("full_pop_cycle_ready", 64'(seen_req_ready), 64'd0);
      in_RDATA_VALID = 1'b0;
      cycle_model();
      check("after_pop_grant", 64'(seen_req_ready), 64'd1);

      // Interleaved lengths with a requester stall in the middle of a burst.
      do_reset();
      apply_stimulus(1, 2'b10, 0, 0, 32'h800, 2, 1, 0, 2'b11);
      cycle_model();
      check("il_grant1", 64'(seen_req_ready), 64'd2);
      apply_stimulus(1, 2'b01, 32'h900, 0, 0, 0, 1, 0, 2'b11);
      cycle_model();
      check("il_grant0", 64'(seen_req_ready), 64'd1);
      apply_stimulus(1, 2'b00, 0, 0, 0, 0, 1, 0, 2'b11);
      cycle_model();
      p0_beats = 0;
      p1_beats = 0;
      lasts = 0;
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(1, 2'b00, 0, 0, 0, 0, 1, 1, (i == 1 || i == 2) ? 2'b01 : 2'b11);
         cycle_model();
         if (i == 1 || i == 2) begin
            check("il_stall_ready", 64'(seen_rrdy), 64'd0);
            check("il_stall_valid", 64'(seen_rdv), 64'd2);
         end else begin
            if (seen_rdv == 2'b01) p0_beats++;
            if (seen_rdv == 2'b10) p1_beats++;
            if (seen_last) lasts++;
         end
      end
      check("il_p1_beats", 64'(p1_beats), 64'd3);
      check("il_p0_beats", 64'(p0_beats), 64'd1);
      check("il_lasts", 64'(lasts), 64'd2);

      // Reset in the middle of a burst drops everything and restarts arbitration at port 0.
      do_reset();
      apply_stimulus(1, 2'b01, 32'h10, 3, 32'h20, 3, 1, 0, 2'b11);
      cycle_model();
      apply_stimulus(1, 2'b10, 32'h10, 3, 32'h20, 3, 1, 0, 2'b11);
      cycle_model();
      apply_stimulus(1, 2'b01, 32'h30, 3, 32'h20, 3, 1, 0, 2'b11);
      cycle_model();
      apply_stimulus(1, 2'b00, 0, 0, 0, 0, 1, 1, 2'b11);
      cycle_model();
      cycle_model();
      apply_stimulus(0, 2'b11, 32'h40, 1, 32'h50, 1, 1, 1, 2'b11);
      cycle_model();
      check("rst_req_ready", 64'(seen_req_ready), 64'd0);
      check("rst_rdv", 64'(seen_rdv), 64'd0);
      apply_stimulus(1, 2'b11, 32'h40, 1, 32'h50, 1, 1, 1, 2'b11);
      cycle_model();
      check("post_rst_grant", 64'(seen_req_ready), 64'd1);
      check("post_rst_rdv", 64'(seen_rdv), 64'd0);
      check("post_rst_rrdy", 64'(seen_rrdy), 64'd0);

      // Randomized traffic against the reference model, with occasional resets.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         apply_stimulus($urandom_range(0, 199) != 0,
                        2'($urandom),
                        $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3),
                        $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3),
                        $urandom_range(0, 3) != 0,
                        $urandom_range(0, 1) == 1,
                        2'($urandom | $urandom));
         cycle_model();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
